if_id_queue: RTL

- Parametrised instruction buffer between fetch (IF) and decode (ID); successor to the single-entry IF/ID pipeline register.
- Decouples fetch from decode with a DEPTH-entry FIFO of {pc, inst} pairs and valid/ready handshakes on both sides.
- A branch/flush from EX discards all buffered and in-flight instructions.
- Decode sees BUBBLE_INST whenever the queue is empty.

---
 rtl/if_id_queue_if.sv | 30 +++
 rtl/if_id_queue.sv | 68 ++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch, the IF/ID queue and decode.
// slave is the queue's view; master is the view of whoever drives fetch/decode.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] pc_i;
    logic [INST_W-1:0] inst_i;
    logic              flush_i;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output in_valid, pc_i, inst_i, flush_i, out_ready,
        input  in_ready, out_valid, pc_o, inst_o, count_o
    );

    modport slave (
        input  in_valid, pc_i, inst_i, flush_i, out_ready,
        output in_ready, out_valid, pc_o, inst_o, count_o
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry {pc, inst} FIFO between fetch and decode with EX flush.
// Empty queue presents BUBBLE_INST / pc 0 to decode; no empty bypass.
module if_id_queue #(
    parameter int                  ADDR_W      = 32,
    parameter int                  INST_W      = 32,
    parameter int                  DEPTH       = 4,
    parameter logic [INST_W-1:0]   BUBBLE_INST = '0
) (
    input  logic           clk,
    input  logic           rst,
    if_id_queue_if.slave   q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;

    // Full/empty come from the occupancy count; equal pointers are ambiguous.
    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(DEPTH));

    assign push = q.in_valid  & not_full  & ~q.flush_i;
    assign pop  = not_empty   & q.out_ready & ~q.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.pc_i;
            inst_mem[wr_ptr] <= q.inst_i;
        end
    end

    assign q.in_ready  = not_full;
    assign q.out_valid = not_empty;
    assign q.count_o   = count;
    assign q.pc_o      = not_empty ? pc_mem[rd_ptr]   : '0;
    assign q.inst_o    = not_empty ? inst_mem[rd_ptr] : BUBBLE_INST;
endmodule
